// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath signal bundle for the multicycle ARM controller
interface multicycle_ctrl_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  Flags;
  logic [3:0]  state;
  logic        illegal;

  // master = controller, slave = datapath
  modport master (
    input  Instr, ALUFlags,
    output PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, Flags, state, illegal
  );
  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl, Flags, state, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FSM control unit sequencing the 32-bit multicycle ARM datapath
module multicycle_ctrl (
  input  logic            clk,
  input  logic            reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t      cur_state, nxt_state;
  logic [3:0]  flags_q;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cond;
  logic        rd_is_pc;
  logic [1:0]  alu_dec;
  logic        cmd_ok;
  logic        cond_ex;
  logic        n_f, z_f, c_f, v_f;

  logic        pcw, rw, mw, irw, adr, ill;
  logic [1:0]  src_a, src_b, res_src, alu_ctl;

  assign op       = bus.Instr[27:26];
  assign funct    = bus.Instr[25:20];
  assign cond     = bus.Instr[31:28];
  assign rd_is_pc = (bus.Instr[15:12] == 4'hf);

  always_comb begin
    alu_dec = 2'b00;
    cmd_ok  = 1'b1;
    case (funct[4:1])
      4'b0100: alu_dec = 2'b00;
      4'b0010: alu_dec = 2'b01;
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: cmd_ok  = 1'b0;
    endcase
  end

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= FETCH;
      flags_q   <= 4'b0000;
    end else begin
      cur_state <= nxt_state;
      if ((cur_state == EXECR || cur_state == EXECI) && funct[0] && cond_ex) begin
        flags_q[3:2] <= bus.ALUFlags[3:2];
        // logical ops leave carry and overflow untouched
        if (!alu_dec[1])
          flags_q[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nxt_state = FETCH;
    pcw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    irw       = 1'b0;
    adr       = 1'b0;
    ill       = 1'b0;
    src_a     = 2'b00;
    src_b     = 2'b00;
    res_src   = 2'b00;
    alu_ctl   = 2'b00;
    case (cur_state)
      FETCH: begin
        nxt_state = DECODE;
        irw       = 1'b1;
        pcw       = 1'b1;
        src_a     = 2'b01;
        src_b     = 2'b10;
        res_src   = 2'b10;
      end
      DECODE: begin
        // PC+4 computed again here so R15 reads as PC+8
        src_a   = 2'b01;
        src_b   = 2'b10;
        res_src = 2'b10;
        case (op)
          2'b01:   nxt_state = MEMADR;
          2'b10:   nxt_state = BRANCH;
          2'b00: begin
            if (!cmd_ok) begin
              nxt_state = FETCH;
              ill       = 1'b1;
            end else begin
              nxt_state = funct[5] ? EXECI : EXECR;
            end
          end
          default: begin
            nxt_state = FETCH;
            ill       = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        nxt_state = funct[0] ? MEMRD : MEMWR;
        src_b     = 2'b01;
      end
      MEMRD: begin
        nxt_state = MEMWB;
        adr       = 1'b1;
      end
      MEMWB: begin
        res_src = 2'b01;
        rw      = cond_ex;
      end
      MEMWR: begin
        adr = 1'b1;
        mw  = cond_ex;
      end
      EXECR: begin
        nxt_state = ALUWB;
        alu_ctl   = alu_dec;
      end
      EXECI: begin
        nxt_state = ALUWB;
        src_b     = 2'b01;
        alu_ctl   = alu_dec;
      end
      ALUWB: begin
        if (rd_is_pc) pcw = cond_ex;
        else          rw  = cond_ex;
      end
      BRANCH: begin
        src_b   = 2'b01;
        res_src = 2'b10;
        pcw     = cond_ex;
      end
      default: nxt_state = FETCH;
    endcase
  end

  // write enables are held off combinationally for the whole reset window
  assign bus.PCWrite    = pcw & reset;
  assign bus.RegWrite   = rw  & reset;
  assign bus.MemWrite   = mw  & reset;
  assign bus.IRWrite    = irw & reset;
  assign bus.AdrSrc     = adr;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.illegal    = ill;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
  assign bus.Flags      = flags_q;
  assign bus.state      = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with directed instruction vectors
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  multicycle_ctrl_if bus_if ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_bad;
  logic [27:0] expq[$];
  string       nameq[$];

  // {state, PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
  //  ResultSrc, ImmSrc, ALUControl, Flags, illegal}
  function automatic logic [27:0] rec(input logic [3:0] st, input logic [3:0] we,
                                      input logic ad, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rr, input logic [1:0] im,
                                      input logic [1:0] al, input logic [3:0] fl,
                                      input logic il);
    return {st, we, ad, rs, sa, sb, rr, im, al, fl, il};
  endfunction

  function automatic logic [27:0] actual();
    return {bus_if.state, bus_if.PCWrite, bus_if.RegWrite, bus_if.MemWrite, bus_if.IRWrite,
            bus_if.AdrSrc, bus_if.RegSrc, bus_if.ALUSrcA, bus_if.ALUSrcB, bus_if.ResultSrc,
            bus_if.ImmSrc, bus_if.ALUControl, bus_if.Flags, bus_if.illegal};
  endfunction

  task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [27:0] r);
    expq.push_back(r);
    nameq.push_back(name);
  endtask

  task automatic push_fd(input string tag, input logic [1:0] rs, input logic [1:0] im,
                         input logic [3:0] fl, input logic il);
    push({tag, " FETCH"},  rec(4'd0, 4'b1001, 1'b0, rs, 2'b01, 2'b10, 2'b10, im, 2'b00, fl, 1'b0));
    push({tag, " DECODE"}, rec(4'd1, 4'b0000, 1'b0, rs, 2'b01, 2'b10, 2'b10, im, 2'b00, fl, il));
  endtask

  task automatic issue(input logic [31:0] instr, input logic [3:0] af);
    bus_if.Instr    = instr;
    bus_if.ALUFlags = af;
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every sample taken while expectations are pending is scored
  always @(negedge clk) begin
    if (expq.size() > 0) chk(nameq.pop_front(), actual(), expq.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    issue(32'hE0821003, 4'b0000);
    @(posedge clk); #1;
    chk("reset state", {16'h0, bus_if.state, bus_if.PCWrite, bus_if.RegWrite, bus_if.MemWrite,
                        bus_if.IRWrite, bus_if.Flags}, 28'h0);
    reset = 1'b1;

    // ADD R1,R2,R3
    push_fd("ADD", 2'b00, 2'b00, 4'b0000, 1'b0);
    push("ADD EXECR", rec(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0));
    push("ADD ALUWB", rec(4'd8, 4'b0100, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0));
    go(4);

    // LDR R1,[R2,#4]
    issue(32'hE5921004, 4'b0000);
    push_fd("LDR", 2'b00, 2'b01, 4'b0000, 1'b0);
    push("LDR MEMADR", rec(4'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000, 1'b0));
    push("LDR MEMRD",  rec(4'd3, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 1'b0));
    push("LDR MEMWB",  rec(4'd4, 4'b0100, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 4'b0000, 1'b0));
    go(5);

    // STR R1,[R2,#4]
    issue(32'hE5821004, 4'b0000);
    push_fd("STR", 2'b10, 2'b01, 4'b0000, 1'b0);
    push("STR MEMADR", rec(4'd2, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000, 1'b0));
    push("STR MEMWR",  rec(4'd5, 4'b0010, 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 1'b0));
    go(4);

    // SUBS R0,R0,#1 with ALU reporting Z and C
    issue(32'hE2500001, 4'b0110);
    push_fd("SUBS", 2'b00, 2'b00, 4'b0000, 1'b0);
    push("SUBS EXECI", rec(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0));
    push("SUBS ALUWB", rec(4'd8, 4'b0100, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0110, 1'b0));
    go(4);

    // BEQ taken
    issue(32'h0A000002, 4'b0000);
    push_fd("BEQ1", 2'b01, 2'b10, 4'b0110, 1'b0);
    push("BEQ1 BRANCH", rec(4'd9, 4'b1000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'b0110, 1'b0));
    go(3);

    // ORRS R2,R2,#0: N,Z from ALU, C,V kept
    issue(32'hE3922000, 4'b1001);
    push_fd("ORRS", 2'b00, 2'b00, 4'b0110, 1'b0);
    push("ORRS EXECI", rec(4'd7, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 4'b0110, 1'b0));
    push("ORRS ALUWB", rec(4'd8, 4'b0100, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0));
    go(4);

    // BEQ not taken with Z clear
    issue(32'h0A000002, 4'b0000);
    push_fd("BEQ2", 2'b01, 2'b10, 4'b1010, 1'b0);
    push("BEQ2 BRANCH", rec(4'd9, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'b1010, 1'b0));
    go(3);

    // ADD PC,R2,R3: writes PC instead of register file
    issue(32'hE082F003, 4'b0000);
    push_fd("ADDPC", 2'b00, 2'b00, 4'b1010, 1'b0);
    push("ADDPC EXECR", rec(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0));
    push("ADDPC ALUWB", rec(4'd8, 4'b1000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0));
    go(4);

    // cond 1111: NOP
    issue(32'hF0821003, 4'b0000);
    push_fd("NV", 2'b00, 2'b00, 4'b1010, 1'b0);
    push("NV EXECR", rec(4'd6, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0));
    push("NV ALUWB", rec(4'd8, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0));
    go(4);

    // Op = 11 and unsupported cmd (EOR)
    issue(32'hEC000000, 4'b0000);
    push_fd("OP11", 2'b00, 2'b11, 4'b1010, 1'b1);
    go(2);
    issue(32'hE0211003, 4'b0000);
    push_fd("EOR", 2'b00, 2'b00, 4'b1010, 1'b1);
    go(2);

    // LDR interrupted by reset during MEMRD
    issue(32'hE5921004, 4'b0000);
    push_fd("LDRRST", 2'b00, 2'b01, 4'b1010, 1'b0);
    push("LDRRST MEMADR", rec(4'd2, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 4'b1010, 1'b0));
    go(3);
    chk("LDRRST in MEMRD", {24'h0, bus_if.state}, 28'd3);
    #1 reset = 1'b0;
    #1;
    chk("mid reset", {16'h0, bus_if.state, bus_if.PCWrite, bus_if.RegWrite, bus_if.MemWrite,
                      bus_if.IRWrite, bus_if.Flags}, 28'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // BEQ not taken with cleared flags
    issue(32'h0A000002, 4'b0000);
    push_fd("BEQ3", 2'b01, 2'b10, 4'b0000, 1'b0);
    push("BEQ3 BRANCH", rec(4'd9, 4'b0000, 1'b0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 4'b0000, 1'b0));
    go(3);
    chk("BEQ3 back to FETCH", {24'h0, bus_if.state}, 28'd0);

    @(negedge clk); #1;
    chk("scoreboard drained", 28'(expq.size()), 28'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the 32-bit multicycle ARM datapath.
- Decodes the instruction register contents and sequences every instruction through FETCH/DECODE/execute states.
- Drives all datapath selects and write enables, and holds the condition flags.
- Sits beside the datapath; the memory write enable goes to the unified instruction/data memory.

Parameters:
none (fixed to the 32-bit ARM subset: ADD, SUB, AND, ORR, LDR, STR, B)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Instr  in  32  instruction register output; bits [31:12] are used
ALUFlags  in  4  {N,Z,C,V} from the ALU for the current cycle
PCWrite  out  1  PC register enable
RegWrite  out  1  register file write enable
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
AdrSrc  out  1  0 = PC, 1 = Result onto the memory address
RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
ALUSrcA  out  2  00 = A, 01 = PC, 10 = ALUOut
ALUSrcB  out  2  00 = WriteData, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ImmSrc  out  2  equals Instr[27:26]
ALUControl  out  2  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR
Flags  out  4  stored {N,Z,C,V}
state  out  4  current FSM state, for debug
illegal  out  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- Field names: Op = Instr[27:26], Funct = Instr[25:20], Cond = Instr[31:28], Rd = Instr[15:12].
- Reset (reset = 0, asynchronous):
  - state = FETCH (0) and Flags = 0000.
  - PCWrite, RegWrite, MemWrite and IRWrite are forced to 0 while reset is low.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Encodings 10-15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if Op = 01; -> EXECI if Op = 00 and Funct[5] = 1; -> EXECR if Op = 00 and Funct[5] = 0; -> BRANCH if Op = 10.
  - DECODE -> FETCH if Op = 11 or the data-processing cmd is unsupported; illegal pulses and no write is made.
  - MEMADR -> MEMRD if Funct[0] = 1, else -> MEMWR. MEMRD -> MEMWB. EXECR and EXECI -> ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH -> FETCH.
- Per-state outputs (unlisted signals are 0):
  - FETCH: IRWrite = 1, PCWrite = 1, AdrSrc = 0, ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, ALUControl = ADD.
  - DECODE: ALUSrcA = 01, ALUSrcB = 10, ResultSrc = 10, ALUControl = ADD. This makes R15 read as PC+8.
  - MEMADR: ALUSrcA = 00, ALUSrcB = 01, ADD.
  - MEMRD: AdrSrc = 1, ResultSrc = 00.
  - MEMWB: ResultSrc = 01, RegWrite = CondEx.
  - MEMWR: AdrSrc = 1, ResultSrc = 00, MemWrite = CondEx.
  - EXECR: ALUSrcA = 00, ALUSrcB = 00, ALUControl = decoded.
  - EXECI: as EXECR but ALUSrcB = 01.
  - ALUWB: ResultSrc = 00. If Rd = 15: PCWrite = CondEx and RegWrite = 0. Otherwise RegWrite = CondEx.
  - BRANCH: ALUSrcA = 00, ALUSrcB = 01, ResultSrc = 10, ADD, PCWrite = CondEx.
- Decode-derived outputs in every state:
  - ImmSrc = Op.
  - RegSrc[0] = (Op == 10).
  - RegSrc[1] = (Op == 01 & ~Funct[0]), i.e. stores.
- ALU decode from cmd = Funct[4:1]: 0100 -> ADD, 0010 -> SUB, 0000 -> AND, 1100 -> ORR. Any other cmd is unsupported.
- CondEx is combinational from Cond and the stored Flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1.
  - 1111 -> 0, so the instruction executes as a NOP.
- Flags update at the clock edge ending EXECR or EXECI, only when Funct[0] (S) = 1 and CondEx = 1:
  - N and Z are always loaded from ALUFlags.
  - C and V are loaded only for ADD or SUB; AND and ORR keep the old C and V.
  - The new flags are visible from ALUWB onward.
- Latency in cycles (FETCH to the next FETCH): LDR 5, STR 4, data-processing 4, B 3, illegal 2. A condition-failed instruction takes the same cycles with writes suppressed.
- Reset asserted mid-instruction: immediate return to FETCH with Flags cleared; no partial write is completed.

Test Plan:
- Release reset with Instr = 0xE0821003 (ADD R1,R2,R3). Required sequence: FETCH, DECODE, EXECR, ALUWB, FETCH. ALUControl = 00 in EXECR; RegWrite = 1 only in ALUWB; Flags stay 0000.
- Instr = 0xE5921004 (LDR R1,[R2,#4]): MEMADR with ALUSrcB = 01 and ImmSrc = 01, then MEMRD with AdrSrc = 1, then MEMWB with ResultSrc = 01 and RegWrite = 1. 5 cycles total.
- Instr = 0xE5821004 (STR): RegSrc = 10 throughout. MemWrite = 1 for exactly one cycle in MEMWR; RegWrite is never 1.
- Instr = 0xE2500001 (SUBS R0,R0,#1) with ALUFlags = 0110 in EXECI: Flags = 0110 in ALUWB. A following 0x0A000002 (BEQ) asserts PCWrite in BRANCH.
- With Flags = 0000, Instr = 0x0A000002 (BEQ): PCWrite = 0 in BRANCH, return to FETCH after 3 cycles.
- Instr = 0xEC000000 (Op = 11): illegal = 1 in DECODE, then FETCH. Separately, pull reset low during MEMRD: state = 0 and all write enables = 0 immediately.
